// File: rtl/harmonic_pkg.sv
// Shared definitions for the harmonic-sum datapath.
// Holds the Q3.16 fixed-point format constants and the state type used by the
// decimal formatter.
package harmonic_pkg;

  localparam int unsigned Q_INT_BITS  = 3;
  localparam int unsigned Q_FRAC_BITS = 16;
  localparam int unsigned Q_WIDTH     = Q_INT_BITS + Q_FRAC_BITS;

  // 1.0 in Q3.16
  localparam logic [Q_WIDTH-1:0] Q_ONE = 19'h10000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } fmt_state_t;

endpackage

// File: rtl/frac_mul10.sv
// Combinational multiply-by-ten step for fraction-to-decimal conversion.
// Ports:
//   frac      - current binary fraction (FRAC_BITS wide)
//   digit     - integer carry-out of frac*10, always 0..9
//   frac_next - remaining fraction after removing that digit
module frac_mul10 #(
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic [FRAC_BITS-1:0] frac,
  output logic [3:0]           digit,
  output logic [FRAC_BITS-1:0] frac_next
);

  logic [FRAC_BITS+3:0] frac_ext;
  logic [FRAC_BITS+3:0] prod;

  always_comb begin
    frac_ext  = {4'b0000, frac};
    // x*10 = x*8 + x*2
    prod      = (frac_ext << 3) + (frac_ext << 1);
    digit     = prod[FRAC_BITS+3:FRAC_BITS];
    frac_next = prod[FRAC_BITS-1:0];
  end

endmodule

// File: rtl/harmonic_dec_formatter.sv
// Converts an unsigned fixed-point value (INT_BITS.FRAC_BITS) into one integer
// digit and FRAC_DIGITS truncated BCD fraction digits, one digit per clock.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   start       - conversion request, only honoured while idle
//   value       - fixed-point input, captured when start is accepted
//   busy        - high while converting or presenting the result
//   done        - one-cycle pulse when int_digit/frac_digits are updated
//   int_digit   - integer part, zero-extended to 4 bits
//   frac_digits - BCD fraction, tenths in the top nibble
module harmonic_dec_formatter
  import harmonic_pkg::*;
#(
  parameter int unsigned FRAC_DIGITS = 4,
  parameter int unsigned FRAC_BITS   = 16,
  parameter int unsigned INT_BITS    = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [INT_BITS+FRAC_BITS-1:0] value,
  output logic                        busy,
  output logic                        done,
  output logic [3:0]                  int_digit,
  output logic [4*FRAC_DIGITS-1:0]    frac_digits
);

  localparam int unsigned DigW = 4 * FRAC_DIGITS;
  localparam logic [2:0]  LastCnt = 3'(FRAC_DIGITS - 1);

  fmt_state_t           state_q, state_d;
  logic [INT_BITS-1:0]  int_q, int_d;
  logic [FRAC_BITS-1:0] frac_q, frac_d;
  logic [DigW-1:0]      shift_q, shift_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [3:0]           int_digit_q, int_digit_d;
  logic [DigW-1:0]      frac_digits_q, frac_digits_d;

  logic [3:0]           step_digit;
  logic [FRAC_BITS-1:0] step_frac;

  frac_mul10 #(
    .FRAC_BITS (FRAC_BITS)
  ) u_frac_mul10 (
    .frac      (frac_q),
    .digit     (step_digit),
    .frac_next (step_frac)
  );

  always_comb begin
    state_d       = state_q;
    int_d         = int_q;
    frac_d        = frac_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    int_digit_d   = int_digit_q;
    frac_digits_d = frac_digits_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CONVERT;
          int_d   = value[INT_BITS+FRAC_BITS-1:FRAC_BITS];
          frac_d  = value[FRAC_BITS-1:0];
          shift_d = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CONVERT: begin
        frac_d        = step_frac;
        // New digit enters at the bottom; earlier (more significant) digits move up.
        shift_d[3:0]  = step_digit;
        for (int unsigned i = 1; i < FRAC_DIGITS; i++) begin
          shift_d[4*i +: 4] = shift_q[4*(i-1) +: 4];
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LastCnt) begin
          state_d       = DONE;
          done_d        = 1'b1;
          // Publish only the complete result so outputs never show partial digits.
          int_digit_d   = 4'(int_q);
          frac_digits_d = shift_d;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      int_q         <= '0;
      frac_q        <= '0;
      shift_q       <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      int_digit_q   <= '0;
      frac_digits_q <= '0;
    end else begin
      state_q       <= state_d;
      int_q         <= int_d;
      frac_q        <= frac_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      int_digit_q   <= int_digit_d;
      frac_digits_q <= frac_digits_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign int_digit   = int_digit_q;
  assign frac_digits = frac_digits_q;

endmodule

// File: tb/tb_harmonic_dec_formatter.sv
// Self-checking bench for harmonic_dec_formatter (default parameters).
module tb_harmonic_dec_formatter;

  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [18:0]   value;
  logic          busy;
  logic          done;
  logic [3:0]    int_digit;
  logic [4*FD-1:0] frac_digits;

  int n_vec  = 0;
  int n_fail = 0;

  harmonic_dec_formatter #(
    .FRAC_DIGITS (FD),
    .FRAC_BITS   (16),
    .INT_BITS    (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .value       (value),
    .busy        (busy),
    .done        (done),
    .int_digit   (int_digit),
    .frac_digits (frac_digits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0]     v;
    logic [3:0]      exp_int;
    logic [4*FD-1:0] exp_frac;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Decimal truncation of the fraction: floor(f * 10^FD / 2^16), emitted as BCD.
  function automatic logic [4*FD-1:0] ref_frac(input logic [18:0] v);
    longint pw = 1;
    longint d;
    logic [4*FD-1:0] r = '0;
    for (int i = 0; i < FD; i++) pw = pw * 10;
    d = (longint'(v[15:0]) * pw) / 65536;
    for (int i = 0; i < FD; i++) begin
      r[4*i +: 4] = 4'(d % 10);
      d = d / 10;
    end
    return r;
  endfunction

  // Starts one conversion; lat is the number of edges after the start edge
  // until done is seen, or -1 on timeout.
  task automatic run_conv(input logic [18:0] v, output int lat);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 19'($urandom);  // must not disturb the captured value
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic conv_and_check(input string tag, input logic [18:0] v,
                                input logic [3:0] ei, input logic [4*FD-1:0] ef);
    int lat;
    run_conv(v, lat);
    chk({tag, " latency"}, 32'(lat), 32'(FD));
    chk({tag, " int_digit"}, 32'(int_digit), 32'(ei));
    chk({tag, " frac_digits"}, 32'(frac_digits), 32'(ef));
    chk({tag, " busy in done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, " done width"}, 32'(done), 32'd0);
    chk({tag, " busy cleared"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int bcnt, dcnt, lat;
    logic [18:0] r;

    vecs[0] = '{19'h10000, 4'd1, 16'h0000};
    vecs[1] = '{19'h18000, 4'd1, 16'h5000};
    vecs[2] = '{19'h1D555, 4'd1, 16'h8333};
    vecs[3] = '{19'h7FFFF, 4'd7, 16'h9999};
    vecs[4] = '{19'h00000, 4'd0, 16'h0000};

    reset = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset int", 32'(int_digit), 32'd0);
    chk("reset frac", 32'(frac_digits), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      conv_and_check($sformatf("table[%0d]", i), vecs[i].v, vecs[i].exp_int, vecs[i].exp_frac);
    end

    // Outputs hold after done.
    repeat (3) @(posedge clk);
    #1;
    chk("hold int", 32'(int_digit), 32'd0);
    chk("hold frac", 32'(frac_digits), 32'd0);

    // Second start during CONVERT is ignored.
    @(negedge clk);
    start = 1'b1;
    value = 19'h18000;
    @(posedge clk);
    #1;
    start = 1'b0;
    bcnt = int'(busy);
    dcnt = int'(done);
    @(negedge clk);
    start = 1'b1;
    value = 19'h7FFFF;
    for (int n = 0; n < 11; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      bcnt += int'(busy);
      dcnt += int'(done);
    end
    chk("ignore busy cycles", 32'(bcnt), 32'd5);
    chk("ignore done pulses", 32'(dcnt), 32'd1);
    chk("ignore int", 32'(int_digit), 32'd1);
    chk("ignore frac", 32'(frac_digits), 32'h5000);

    // Reset in the second CONVERT cycle discards the conversion.
    conv_and_check("pre-reset", 19'h1D555, 4'd1, 16'h8333);
    @(negedge clk);
    start = 1'b1;
    value = 19'h7FFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset int", 32'(int_digit), 32'd0);
    chk("midreset frac", 32'(frac_digits), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      dcnt += int'(done);
    end
    chk("midreset no done", 32'(dcnt), 32'd0);
    conv_and_check("post-reset", 19'h18000, 4'd1, 16'h5000);

    // Start held high: second conversion re-samples value after DONE.
    @(negedge clk);
    start = 1'b1;
    value = 19'h10000;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("held first int", 32'(int_digit), 32'd1);
    chk("held first frac", 32'(frac_digits), 32'h0000);
    value = 19'h7FFFF;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    chk("held restart latency", 32'(lat), 32'(FD + 2));
    chk("held second int", 32'(int_digit), 32'd7);
    chk("held second frac", 32'(frac_digits), 32'h9999);
    repeat (3) @(posedge clk);

    // Random values against the arithmetic model.
    for (int i = 0; i < 25; i++) begin
      r = 19'($urandom);
      conv_and_check($sformatf("rand[%0d] v=%05h", i, r), r, 4'(r[18:16]), ref_frac(r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
